// File: rtl/banco_registradores_param_pkg.sv
// Shared processor package for the register bank.
// Holds the default special register indices and the output handshake
// state encoding, so that the bank, its sub-modules and any neighbouring
// datapath blocks agree on them.
package banco_registradores_param_pkg;

   localparam int IDX_ZERO = 26;
   localparam int IDX_RE   = 28;
   localparam int IDX_LO   = 29;
   localparam int IDX_HI   = 30;
   localparam int IDX_RA   = 31;

   typedef enum logic {
      SAIDA_IDLE = 1'b0,
      SAIDA_HOLD = 1'b1
   } saida_state_e;

endpackage

// File: rtl/banco_registradores_param_if.sv
// Bus bundle for banco_registradores_param.
// Groups the read ports, the general and HI/LO write ports, the input
// channel and the output channel. The master drives requests and write
// data; the slave (the register bank) returns read data and handshakes.
//   rd_addr/rd_data      : packed read ports, port k at slice k
//   EscreveReg/Reg_escrita/Dados_escrita : general write port
//   WriteHILO/ResultadoHILO              : {HI,LO} write port
//   in_valid/in_ready/in_data            : input channel into RE
//   out_req/out_valid/out_ready/out_data/out_busy : output channel
interface banco_registradores_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int N_RD   = 2
);

   logic [N_RD*ADDR_W-1:0] rd_addr;
   logic [N_RD*DATA_W-1:0] rd_data;

   logic                   EscreveReg;
   logic [ADDR_W-1:0]      Reg_escrita;
   logic [DATA_W-1:0]      Dados_escrita;

   logic                   WriteHILO;
   logic [2*DATA_W-1:0]    ResultadoHILO;

   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_W-1:0]      in_data;

   logic                   out_req;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_W-1:0]      out_data;
   logic                   out_busy;

   modport master (
      output rd_addr, EscreveReg, Reg_escrita, Dados_escrita,
             WriteHILO, ResultadoHILO, in_valid, in_data,
             out_req, out_ready,
      input  rd_data, in_ready, out_valid, out_data, out_busy
   );

   modport slave (
      input  rd_addr, EscreveReg, Reg_escrita, Dados_escrita,
             WriteHILO, ResultadoHILO, in_valid, in_data,
             out_req, out_ready,
      output rd_data, in_ready, out_valid, out_data, out_busy
   );

endinterface

// File: rtl/banco_registradores_param_saida_handshake.sv
// Output channel of the register bank: captures a word on request and
// holds it under a valid/ready handshake.
//   clk, rst_n    : clock, async active-low reset
//   out_req_i     : capture data_i for output
//   data_i        : word to capture
//   out_ready_i   : consumer ready
//   out_valid_o   : word held and offered
//   out_data_o    : held word
//   out_busy_o    : request rejected this cycle (held word not yet taken)
//
// state      | meaning
// -----------+--------------------------------------------------------
// SAIDA_IDLE | nothing offered; a request loads a word and moves to HOLD
// SAIDA_HOLD | word offered; reload on ready+req, drop req while !ready
module saida_handshake
   import banco_registradores_param_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              out_req_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              out_ready_i,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_busy_o
);

   saida_state_e      state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SAIDA_IDLE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
         SAIDA_IDLE: begin
            if (out_req_i) begin
               state_d = SAIDA_HOLD;
               data_d  = data_i;
            end
         end
         SAIDA_HOLD: begin
            if (out_ready_i) begin
               // Consumer takes the held word this edge; a simultaneous
               // request refills without a bubble.
               if (out_req_i) begin
                  data_d = data_i;
               end else begin
                  state_d = SAIDA_IDLE;
               end
            end
         end
         default: state_d = SAIDA_IDLE;
      endcase
   end

   always_comb begin
      out_valid_o = (state_q == SAIDA_HOLD);
      out_busy_o  = (state_q == SAIDA_HOLD) && out_req_i && !out_ready_i;
      out_data_o  = data_q;
   end

endmodule

// File: rtl/banco_registradores_param.sv
// Parameterised register bank with combinational multi-port read,
// write-through bypass, a hardwired-zero index, a {HI,LO} write port,
// an input channel writing the RE index and a handshaked output channel.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of banco_registradores_param_if (read ports,
//                write ports, input and output channels)
module banco_registradores_param
   import banco_registradores_param_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int N_RD     = 2,
   parameter int ZERO_IDX = IDX_ZERO,
   parameter int RE_IDX   = IDX_RE,
   parameter int LO_IDX   = IDX_LO,
   parameter int HI_IDX   = IDX_HI
) (
   input  logic                        clk,
   input  logic                        rst_n,
   banco_registradores_param_if.slave  bus
);

   localparam int                DEPTH  = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
   localparam logic [ADDR_W-1:0] RE_A   = ADDR_W'(RE_IDX);

   logic [DATA_W-1:0]      regs_q [DEPTH];
   logic [DATA_W-1:0]      regs_d [DEPTH];
   logic                   in_ready_w;
   logic                   in_fire;
   logic [N_RD*DATA_W-1:0] rd_data_w;

   // The general write port owns RE while it targets it, so the input
   // channel is back-pressured instead of silently losing the word.
   assign in_ready_w = !(bus.EscreveReg && (bus.Reg_escrita == RE_A));
   assign in_fire    = bus.in_valid && in_ready_w;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
         if (i == ZERO_IDX) begin
            regs_d[i] = '0;
         end else if (bus.WriteHILO && (i == HI_IDX)) begin
            regs_d[i] = bus.ResultadoHILO[2*DATA_W-1:DATA_W];
         end else if (bus.WriteHILO && (i == LO_IDX)) begin
            regs_d[i] = bus.ResultadoHILO[DATA_W-1:0];
         end else if (bus.EscreveReg && (bus.Reg_escrita == ADDR_W'(i))) begin
            regs_d[i] = bus.Dados_escrita;
         end else if (in_fire && (i == RE_IDX)) begin
            regs_d[i] = bus.in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Reads look at the next-state array, which gives write-through bypass
   // with the same priority the storage update uses.
   always_comb begin
      rd_data_w = '0;
      for (int k = 0; k < N_RD; k++) begin
         if (bus.rd_addr[k*ADDR_W +: ADDR_W] != ZERO_A) begin
            rd_data_w[k*DATA_W +: DATA_W] = regs_d[bus.rd_addr[k*ADDR_W +: ADDR_W]];
         end
      end
   end

   assign bus.rd_data  = rd_data_w;
   assign bus.in_ready = in_ready_w;

   saida_handshake #(
      .DATA_W (DATA_W)
   ) u_saida (
      .clk         (clk),
      .rst_n       (rst_n),
      .out_req_i   (bus.out_req),
      .data_i      (bus.Dados_escrita),
      .out_ready_i (bus.out_ready),
      .out_valid_o (bus.out_valid),
      .out_data_o  (bus.out_data),
      .out_busy_o  (bus.out_busy)
   );

endmodule

// File: tb/tb_banco_registradores_param.sv
module tb_banco_registradores_param;
   import banco_registradores_param_pkg::*;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int DEPTH = 32;

   logic clk;
   logic rst_n;

   banco_registradores_param_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) bus ();

   banco_registradores_param #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: register contents, next contents, output channel.
   logic [DW-1:0] m_regs [DEPTH];
   logic [DW-1:0] m_nxt  [DEPTH];
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          exp_busy;
   logic          exp_ready;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rd_port(input int k);
      return bus.rd_data[k*DW +: DW];
   endfunction

   function automatic int addr_of(input int k);
      return int'(bus.rd_addr[k*AW +: AW]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
      m_valid = 1'b0;
      m_data  = '0;
   endtask

   task automatic idle_inputs();
      bus.rd_addr       = '0;
      bus.EscreveReg    = 1'b0;
      bus.Reg_escrita   = '0;
      bus.Dados_escrita = '0;
      bus.WriteHILO     = 1'b0;
      bus.ResultadoHILO = '0;
      bus.in_valid      = 1'b0;
      bus.in_data       = '0;
      bus.out_req       = 1'b0;
      bus.out_ready     = 1'b0;
   endtask

   // Apply the sources lowest priority first so later ones overwrite.
   task automatic settle_check();
      #2;
      m_nxt = m_regs;
      exp_ready = !(bus.EscreveReg && (int'(bus.Reg_escrita) == IDX_RE));
      if (bus.in_valid && exp_ready) m_nxt[IDX_RE] = bus.in_data;
      if (bus.EscreveReg) m_nxt[int'(bus.Reg_escrita)] = bus.Dados_escrita;
      if (bus.WriteHILO) begin
         m_nxt[IDX_HI] = bus.ResultadoHILO[63:32];
         m_nxt[IDX_LO] = bus.ResultadoHILO[31:0];
      end
      m_nxt[IDX_ZERO] = '0;
      exp_busy = m_valid && bus.out_req && !bus.out_ready;
      chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
      for (int k = 0; k < NR; k++)
         chk($sformatf("rd%0d[%0d]", k, addr_of(k)), 64'(rd_port(k)), 64'(m_nxt[addr_of(k)]));
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      if (m_valid) chk("out_data", 64'(bus.out_data), 64'(m_data));
      chk("out_busy", 64'(bus.out_busy), 64'(exp_busy));
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      if (!m_valid || bus.out_ready) begin
         if (bus.out_req) begin
            m_valid = 1'b1;
            m_data  = bus.Dados_escrita;
         end else begin
            m_valid = 1'b0;
         end
      end
      m_regs = m_nxt;
   endtask

   // Called with rst_n low: every index must read 0 and the output idle,
   // even with a pending rejected-looking request on the inputs.
   task automatic reset_check(input string tag);
      bus.EscreveReg = 1'b0;
      bus.WriteHILO  = 1'b0;
      bus.in_valid   = 1'b0;
      bus.out_req    = 1'b1;
      bus.out_ready  = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         bus.rd_addr = {AW'(DEPTH - 1 - a), AW'(a)};
         #1;
         chk($sformatf("%s_rd0[%0d]", tag, a), 64'(rd_port(0)), 64'd0);
         chk($sformatf("%s_rd1[%0d]", tag, DEPTH - 1 - a), 64'(rd_port(1)), 64'd0);
      end
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_out_busy"}, 64'(bus.out_busy), 64'd0);
      chk({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
      bus.out_req = 1'b0;
   endtask

   int sel;
   int special [5] = '{5, IDX_ZERO, IDX_RE, IDX_LO, IDX_HI};

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_check("rst0");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Bypass on a general write, then the stored value.
      bus.EscreveReg    = 1'b1;
      bus.Reg_escrita   = 5'd5;
      bus.Dados_escrita = 32'hDEADBEEF;
      bus.rd_addr       = {5'd26, 5'd5};
      settle_check();
      chk("bypass_pre", 64'(rd_port(0)), 64'h0000_0000_DEAD_BEEF);
      advance();
      bus.EscreveReg = 1'b0;
      settle_check();
      chk("bypass_post", 64'(rd_port(0)), 64'h0000_0000_DEAD_BEEF);
      advance();

      // HI/LO beats a general write to HI.
      bus.WriteHILO     = 1'b1;
      bus.ResultadoHILO = 64'h1111_2222_3333_4444;
      bus.EscreveReg    = 1'b1;
      bus.Reg_escrita   = 5'd30;
      bus.Dados_escrita = 32'h55;
      settle_check();
      advance();
      bus.WriteHILO  = 1'b0;
      bus.EscreveReg = 1'b0;
      bus.rd_addr    = {5'd29, 5'd30};
      settle_check();
      chk("hilo_hi", 64'(rd_port(0)), 64'h1111_2222);
      chk("hilo_lo", 64'(rd_port(1)), 64'h3333_4444);
      advance();

      // General write to RE blocks the input channel.
      bus.in_valid      = 1'b1;
      bus.in_data       = 32'h7;
      bus.EscreveReg    = 1'b1;
      bus.Reg_escrita   = 5'd28;
      bus.Dados_escrita = 32'h9;
      bus.rd_addr       = {5'd0, 5'd28};
      settle_check();
      chk("in_conflict_ready", 64'(bus.in_ready), 64'd0);
      advance();
      bus.EscreveReg = 1'b0;
      bus.in_valid   = 1'b0;
      settle_check();
      chk("in_conflict_re", 64'(rd_port(0)), 64'h9);
      advance();
      bus.in_valid = 1'b1;
      settle_check();
      chk("in_ready_free", 64'(bus.in_ready), 64'd1);
      advance();
      bus.in_valid = 1'b0;
      settle_check();
      chk("in_capture_re", 64'(rd_port(0)), 64'h7);
      advance();

      // Output held under back-pressure, busy on each rejected request.
      bus.out_req       = 1'b1;
      bus.Dados_escrita = 32'hA;
      bus.out_ready     = 1'b0;
      settle_check();
      chk("out_idle_valid", 64'(bus.out_valid), 64'd0);
      advance();
      bus.Dados_escrita = 32'hB;
      for (int c = 0; c < 3; c++) begin
         settle_check();
         chk($sformatf("out_hold_data%0d", c), 64'(bus.out_data), 64'hA);
         chk($sformatf("out_hold_busy%0d", c), 64'(bus.out_busy), 64'd1);
         advance();
      end
      bus.out_req   = 1'b0;
      bus.out_ready = 1'b1;
      settle_check();
      chk("out_xfer_valid", 64'(bus.out_valid), 64'd1);
      chk("out_xfer_data", 64'(bus.out_data), 64'hA);
      advance();
      settle_check();
      chk("out_after_xfer", 64'(bus.out_valid), 64'd0);
      advance();
      bus.out_ready = 1'b0;

      // Writes to the zero index are discarded.
      bus.EscreveReg    = 1'b1;
      bus.Reg_escrita   = 5'd26;
      bus.Dados_escrita = 32'hFFFF;
      bus.rd_addr       = {5'd26, 5'd26};
      settle_check();
      chk("zero_pre", 64'(rd_port(0)), 64'd0);
      advance();
      bus.EscreveReg = 1'b0;
      settle_check();
      chk("zero_post", 64'(rd_port(1)), 64'd0);
      advance();

      // Randomised traffic against the model.
      for (int n = 0; n < 400; n++) begin
         bus.EscreveReg    = 1'($urandom_range(0, 1));
         sel               = int'($urandom_range(0, 3));
         bus.Reg_escrita   = (sel == 0) ? AW'(special[$urandom_range(0, 4)]) : AW'($urandom_range(0, DEPTH - 1));
         bus.Dados_escrita = $urandom;
         bus.WriteHILO     = ($urandom_range(0, 3) == 0);
         bus.ResultadoHILO = {$urandom, $urandom};
         bus.in_valid      = 1'($urandom_range(0, 1));
         bus.in_data       = $urandom;
         bus.out_req       = 1'($urandom_range(0, 1));
         bus.out_ready     = 1'($urandom_range(0, 1));
         for (int k = 0; k < NR; k++) begin
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      bus.rd_addr[k*AW +: AW] = bus.Reg_escrita;
            else if (sel == 1) bus.rd_addr[k*AW +: AW] = AW'(special[$urandom_range(0, 4)]);
            else               bus.rd_addr[k*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
         end
         settle_check();
         advance();
      end

      // Fill every index, park a word in the output, then reset mid-transfer.
      idle_inputs();
      for (int i = 0; i < DEPTH; i++) begin
         bus.EscreveReg    = 1'b1;
         bus.Reg_escrita   = AW'(i);
         bus.Dados_escrita = $urandom | 32'h1;
         settle_check();
         advance();
      end
      bus.EscreveReg    = 1'b0;
      bus.out_req       = 1'b1;
      bus.Dados_escrita = 32'h1234;
      bus.out_ready     = 1'b0;
      settle_check();
      advance();
      bus.out_req = 1'b0;
      settle_check();
      chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
      rst_n = 1'b0;
      model_reset();
      reset_check("rst1");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_inputs();

      // First edge after release behaves normally.
      bus.EscreveReg    = 1'b1;
      bus.Reg_escrita   = 5'd7;
      bus.Dados_escrita = 32'hCAFE_0007;
      bus.out_req       = 1'b1;
      bus.rd_addr       = {5'd7, 5'd7};
      settle_check();
      advance();
      bus.EscreveReg = 1'b0;
      bus.out_req    = 1'b0;
      settle_check();
      chk("post_rst_reg7", 64'(rd_port(1)), 64'hCAFE_0007);
      chk("post_rst_out", 64'(bus.out_data), 64'hCAFE_0007);
      advance();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
